// File: rtl/sid_note_scheduler.sv
// Timed note-event scheduler for one SID voice: queues {frequency, waveform, duration}
// events and plays them back-to-back with a gate-off release gap between notes.
module sid_note_scheduler #(
  parameter int DEPTH     = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     push,
  input  logic [15:0]              push_freq,
  input  logic [7:0]               push_wave,
  input  logic [7:0]               push_dur,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              frequency,
  output logic [7:0]               waveform,
  output logic                     busy,
  output logic                     note_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PRE_ONE  = 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_ONE  = 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t         state;
  logic [15:0]    q_freq [DEPTH];
  logic [6:0]     q_wave [DEPTH];
  logic [7:0]     q_dur  [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  presc;
  logic [GW-1:0]  gap_cnt;
  logic [7:0]     remaining;
  logic           flush_pend;
  logic           pop, push_ok, tick;

  assign pop     = (state == LOAD);
  assign push_ok = push && (!full || pop) && !flush;
  assign tick    = (presc == PRE_LAST);
  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign busy    = (state != IDLE);

  // NOTE: queue storage has no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_freq[wr_ptr] <= push_freq;
      q_wave[wr_ptr] <= push_wave[7:1];
      q_dur[wr_ptr]  <= push_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: all state and outputs below use non-blocking assignments so every
  // branch sees the pre-edge values of state, presc and remaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      gap_cnt    <= '0;
      remaining  <= '0;
      frequency  <= '0;
      waveform   <= '0;
      note_done  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      note_done <= 1'b0;
      presc     <= tick ? '0 : presc + PRE_ONE;
      case (state)
        IDLE: begin
          waveform[0] <= 1'b0;
          if (enable && !empty && !flush) state <= LOAD;
        end
        LOAD: begin
          frequency <= q_freq[rd_ptr];
          waveform  <= {q_wave[rd_ptr], 1'b1};
          remaining <= q_dur[rd_ptr];
          presc     <= '0;
          state     <= PLAY;
        end
        PLAY: begin
          if (flush) begin
            // Aborted note: release immediately, no completion pulse.
            waveform[0] <= 1'b0;
            presc       <= '0;
            gap_cnt     <= '0;
            flush_pend  <= 1'b1;
            state       <= GAP;
          end else if (tick) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              waveform[0] <= 1'b0;
              presc       <= '0;
              gap_cnt     <= '0;
              note_done   <= 1'b1;
              state       <= GAP;
            end
          end
        end
        GAP: begin
          if (flush) flush_pend <= 1'b1;
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt    <= '0;
              flush_pend <= 1'b0;
              if (enable && !empty && !flush && !flush_pend) state <= LOAD;
              else                                           state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sid_note_scheduler.md
Name: sid_note_scheduler

Overview:
- Note-event scheduler that drives the SID voice's frequency and waveform/gate inputs from a small queue of timed notes.
- A host or sequencer pushes {frequency, waveform, duration} events. The block plays them back-to-back with exact tick timing.
- Between notes it inserts a gate-off release gap so the voice's ADSR retriggers on every note.
- Its outputs feed the voice source mux in place of raw register values.

Parameters:
- DEPTH, 4, queue depth in events; power of two, >=2.
- TICK_DIV, 50000, clocks per duration tick (1 ms at 50 MHz); >=2.
- GAP_TICKS, 1, gate-off ticks between notes; >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allow new notes to start
- push  in  1  enqueue one event this cycle
- push_freq  in  16  event frequency word
- push_wave  in  8  event waveform/control byte; bit0 (gate) is ignored
- push_dur  in  8  gate-on length in ticks; 0 means 256
- flush  in  1  clear queue and abort the current note
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  $clog2(DEPTH)+1  queued events, excluding the note in play
- frequency  out  16  to voice frequency input
- waveform  out  8  to voice waveform input; bit0 = gate
- busy  out  1  state != IDLE
- note_done  out  1  one-cycle pulse when a note ends naturally

Behaviour:
- Reset:
  - All outputs 0; empty=1.
  - Queue cleared; state IDLE; tick prescaler and remaining counter 0.
  - Reset asserted mid-note drops the gate asynchronously.
- Queue:
  - Synchronous FIFO; pop occurs only in LOAD.
  - push accepted iff (!full || pop same cycle) and !flush. Otherwise the push is silently dropped, with no state change.
  - count, full and empty update on the edge after the push/pop.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick asserts when count==TICK_DIV-1.
  - Forced to 0 on exit from LOAD and on entry to GAP.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: waveform[0]=0; frequency and waveform[7:1] hold last values. If enable && !empty, go to LOAD.
  - LOAD (1 cycle):
    - Pop head.
    - Register frequency<=freq, waveform<={wave[7:1],1}, remaining<=dur.
    - Go to PLAY.
  - PLAY:
    - On tick, remaining decrements (8-bit, so 0 wraps to 255).
    - On tick with remaining==1: go to GAP, waveform[0]<=0, pulse note_done.
    - Gate-high time is exactly dur*TICK_DIV clocks (256*TICK_DIV for dur=0).
  - GAP:
    - Count GAP_TICKS ticks with waveform[0]=0; frequency and waveform[7:1] hold.
    - Then go to LOAD if enable && !empty, else IDLE.
- Latency: gate rises after the 2nd rising edge following the edge that accepts a push, when in IDLE with enable=1.
- enable deasserted: a note in PLAY or GAP completes normally; no new LOAD. Reasserting it in IDLE resumes within 1 cycle.
- flush:
  - Queue cleared next edge.
  - PLAY goes to GAP immediately (gate off), with no note_done.
  - GAP completes, then goes to IDLE.
  - IDLE and LOAD are unaffected apart from the queue. A LOAD's pop still completes.
  - flush has priority over a simultaneous push.
- Back-to-back: the gate is low for exactly GAP_TICKS*TICK_DIV+1 clocks between notes (GAP duration plus the LOAD cycle).
- push_wave bit0 never reaches the output directly; the gate is owned solely by the FSM.

Test Plan (TICK_DIV=4, GAP_TICKS=1, DEPTH=4):
- Reset, then push {0x1234, 0x20, 3} with enable=1:
  - gate high 2 edges after the push edge, for exactly 12 clocks.
  - frequency=0x1234, waveform=0x21 during the note.
  - note_done pulses once; then IDLE with busy=0.
- Push two notes (dur 2, dur 1) back-to-back:
  - gate high 8 clocks, low 5 clocks, high 4 clocks.
  - frequency switches at the second LOAD edge; two note_done pulses.
- Push 5 events while enable=0:
  - count=4, full=1; 5th event dropped.
  - Then enable=1: exactly 4 notes play in FIFO order.
- Full queue with push coinciding with a LOAD pop: push accepted, count stays 4.
- flush mid-PLAY with 2 queued:
  - gate drops next edge, no note_done, count=0.
  - busy=0 after 4 GAP clocks.
  - A push in the flush cycle is dropped.
- push_dur=0: gate high 1024 clocks. Assert rst_n=0 mid-note: waveform=0 and frequency=0 immediately, queue empty.
